// File: rtl/xalu_ctrl_if.sv
// XALU issue/result bundle between the E stage and the multiply/divide controller.
// The master side issues operations; the slave side is the controller.
interface xalu_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        d_is_xalu;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall;

   modport master (
      output start, op, a, b, cancel, d_is_xalu,
      input  busy, hi, lo, stall
   );

   modport slave (
      input  start, op, a, b, cancel, d_is_xalu,
      output busy, hi, lo, stall
   );
endinterface

// File: rtl/xalu_ctrl.sv
// Fixed-latency multiply/divide controller owning HI/LO for the E stage.
// The result is computed at issue, held pending, and committed when the busy window ends.
module xalu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   xalu_ctrl_if.slave bus
);

   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [W-1:0]     hi_q, hi_n, lo_q, lo_n;
   logic [W-1:0]     pend_hi, pend_hi_n, pend_lo, pend_lo_n;
   logic             pend_wr, pend_wr_n;
   logic             busy_q;

   // Result datapath, evaluated on the issue cycle only.
   logic [2*W-1:0] prod_s, prod_u;
   logic [W-1:0]   mag_a, mag_b, sdiv_b, udiv_b;
   logic [W-1:0]   quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;
   logic           b_zero, long_op;

   // Two's-complement product of sign-extended operands equals the signed product mod 2^64.
   assign prod_s = {{W{bus.a[W-1]}}, bus.a} * {{W{bus.b[W-1]}}, bus.b};
   assign prod_u = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};

   assign b_zero = (bus.b == '0);
   assign mag_a  = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
   assign mag_b  = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;
   assign sdiv_b = b_zero ? W'(1) : mag_b;
   assign udiv_b = b_zero ? W'(1) : bus.b;

   // Signed divide via magnitudes; quotient truncates toward zero, remainder follows dividend.
   assign quo_m = mag_a / sdiv_b;
   assign rem_m = mag_a % sdiv_b;
   assign quo_s = (bus.a[W-1] ^ bus.b[W-1]) ? (~quo_m + W'(1)) : quo_m;
   assign rem_s = bus.a[W-1] ? (~rem_m + W'(1)) : rem_m;
   assign quo_u = bus.a / udiv_b;
   assign rem_u = bus.a % udiv_b;

   assign long_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         hi_q    <= hi_n;
         lo_q    <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_wr <= pend_wr_n;
         busy_q  <= (state_n == RUN);
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      hi_n      = hi_q;
      lo_n      = lo_q;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_wr_n = pend_wr;

      case (state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               case (bus.op)
                  OP_MULT: begin
                     {pend_hi_n, pend_lo_n} = prod_s;
                     pend_wr_n = 1'b1;
                     count_n   = CNT_W'(MULT_CYCLES);
                     state_n   = RUN;
                  end
                  OP_MULTU: begin
                     {pend_hi_n, pend_lo_n} = prod_u;
                     pend_wr_n = 1'b1;
                     count_n   = CNT_W'(MULT_CYCLES);
                     state_n   = RUN;
                  end
                  OP_DIV: begin
                     pend_hi_n = rem_s;
                     pend_lo_n = quo_s;
                     pend_wr_n = !b_zero;
                     count_n   = CNT_W'(DIV_CYCLES);
                     state_n   = RUN;
                  end
                  OP_DIVU: begin
                     pend_hi_n = rem_u;
                     pend_lo_n = quo_u;
                     pend_wr_n = !b_zero;
                     count_n   = CNT_W'(DIV_CYCLES);
                     state_n   = RUN;
                  end
                  OP_MTHI: hi_n = bus.a;
                  OP_MTLO: lo_n = bus.a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Issue is blocked upstream while busy, so start is not looked at here.
            if (bus.cancel) begin
               state_n   = IDLE;
               count_n   = '0;
               pend_wr_n = 1'b0;
            end else if (count == CNT_W'(1)) begin
               state_n   = IDLE;
               count_n   = '0;
               pend_wr_n = 1'b0;
               if (pend_wr) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end else begin
               count_n = count - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.stall = bus.d_is_xalu & (busy_q | (bus.start & long_op));

endmodule

// File: tb/tb_xalu_ctrl.sv
// Bench for xalu_ctrl: directed stimulus, a reference model of HI/LO and the busy
// window, a per-cycle comparison against that model, and hand-computed spot values.
module tb_xalu_ctrl;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   xalu_ctrl_if bus ();

   xalu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles plus the value HI/LO will take at commit.
   int          m_left;
   logic        m_wr;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   longint      sa, sb, sp, sq, sr;
   longint unsigned ua, ub, up;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left = 0;
         m_wr   = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (m_left > 0) begin
         if (bus.cancel) m_left = 0;
         else begin
            m_left = m_left - 1;
            if (m_left == 0 && m_wr) begin
               m_hi = m_phi;
               m_lo = m_plo;
            end
         end
      end else if (bus.start && !bus.cancel) begin
         sa = longint'($signed(bus.a));
         sb = longint'($signed(bus.b));
         ua = {32'h0, bus.a};
         ub = {32'h0, bus.b};
         case (bus.op)
            3'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0];
                        m_wr = 1'b1; m_left = MULT_N; end
            3'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0];
                        m_wr = 1'b1; m_left = MULT_N; end
            3'd3: begin
               m_wr = (sb != 0); m_left = DIV_N;
               if (sb != 0) begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
            end
            3'd4: begin
               m_wr = (ub != 0); m_left = DIV_N;
               if (ub != 0) begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
            end
            3'd5: m_hi = bus.a;
            3'd6: m_lo = bus.a;
            default: ;
         endcase
      end
   end

   // Every cycle out of reset, outputs must track the model.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         check("model_busy", 32'(bus.busy), 32'(m_left > 0));
         check("model_hi", bus.hi, m_hi);
         check("model_lo", bus.lo, m_lo);
         check("model_stall", 32'(bus.stall),
               32'(bus.d_is_xalu && (m_left > 0 ||
                   (bus.start && bus.op >= 3'd1 && bus.op <= 3'd4))));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic c);
      bus.start  = 1'b1;
      bus.op     = o;
      bus.a      = x;
      bus.b      = y;
      bus.cancel = c;
      tick();
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.cancel = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int n_exp,
                         input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      int n;
      issue(o, x, y, 1'b0);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check({name, "_cycles"}, 32'(n), 32'(n_exp));
      check({name, "_hi"}, bus.hi, hi_exp);
      check({name, "_lo"}, bus.lo, lo_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.op        = 3'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cancel    = 1'b0;
      bus.d_is_xalu = 1'b0;
      #3;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_hi", bus.hi, 32'h0);
      check("reset_lo", bus.lo, 32'h0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu", 3'd2, 32'hFFFF_FFFD, 32'd5, 5, 32'h0000_0004, 32'hFFFF_FFF1);
      run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

      issue(3'd5, 32'h11, 32'h0, 1'b0);
      check("mthi_hi", bus.hi, 32'h11);
      check("mthi_busy", 32'(bus.busy), 32'd0);
      issue(3'd6, 32'h22, 32'h0, 1'b0);
      check("mtlo_lo", bus.lo, 32'h22);
      run_op("div0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
      run_op("divu0", 3'd4, 32'd9, 32'd0, 10, 32'h11, 32'h22);

      // Stall window with an XALU instruction held in D.
      bus.d_is_xalu = 1'b1;
      bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
      #1;
      check("stall_start", 32'(bus.stall), 32'd1);
      tick();
      bus.start = 1'b0; bus.op = 3'd0;
      for (int i = 0; i < 5; i++) begin
         check("stall_busy", 32'(bus.stall), 32'd1);
         tick();
      end
      check("stall_commit", 32'(bus.stall), 32'd0);
      check("stall_commit_busy", 32'(bus.busy), 32'd0);
      check("stall_commit_lo", bus.lo, 32'hFFFF_FFF1);
      bus.d_is_xalu = 1'b0;
      bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd2; bus.b = 32'd3;
      #1;
      check("nostall_start", 32'(bus.stall), 32'd0);
      tick();
      bus.start = 1'b0; bus.op = 3'd0;
      for (int i = 0; i < 5; i++) begin
         check("nostall_busy", 32'(bus.stall), 32'd0);
         tick();
      end
      check("multu_small_hi", bus.hi, 32'h0);
      check("multu_small_lo", bus.lo, 32'h6);

      // Cancel on the 4th busy cycle of a mult.
      issue(3'd1, 32'd7, 32'd7, 1'b0);
      tick(); tick(); tick();
      check("cancel_prebusy", 32'(bus.busy), 32'd1);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("cancel_busy", 32'(bus.busy), 32'd0);
      check("cancel_hi", bus.hi, 32'h0);
      check("cancel_lo", bus.lo, 32'h6);
      tick(); tick(); tick();
      check("cancel_later_lo", bus.lo, 32'h6);

      // cancel together with start drops the start.
      issue(3'd4, 32'd100, 32'd7, 1'b1);
      check("cancel_start_busy", 32'(bus.busy), 32'd0);
      tick();
      check("cancel_start_busy2", 32'(bus.busy), 32'd0);

      // Asynchronous reset on the 3rd busy cycle of a divu.
      issue(3'd4, 32'd100, 32'd7, 1'b0);
      tick(); tick();
      check("rst_pre_busy", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_hi", bus.hi, 32'h0);
      check("rst_mid_lo", bus.lo, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      run_op("post_rst_mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
